// File: rtl/ledstrip_pkg.sv
// Shared types and constants for the ws2812b frame sequencer.
package ledstrip_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam int unsigned PIXEL_W = 24;
  localparam int unsigned CH_W    = 8;
  localparam int unsigned G_LSB   = 16;
  localparam int unsigned R_LSB   = 8;
  localparam int unsigned B_LSB   = 0;

endpackage

// File: rtl/ledstrip_pixel_scale.sv
// One colour channel scaled by global brightness: (c * (b+1)) >> 8.
module ledstrip_pixel_scale
  import ledstrip_pkg::*;
(
  input  logic [CH_W-1:0] i_ch,
  input  logic [7:0]      i_brightness,
  output logic [CH_W-1:0] o_ch
);

  logic [15:0] w_prod;

  assign w_prod = 16'(i_ch) * (16'(i_brightness) + 16'd1);
  assign o_ch   = w_prod[15:8];

endmodule

// File: rtl/ledstrip_frame_seq.sv
// Frame sequencer: pixel buffer streamed to the ws2812b driver over valid/ready.
// Optional brightness scaling under LEDSTRIP_BRIGHTNESS_EN.
module ledstrip_frame_seq
  import ledstrip_pkg::*;
#(
  parameter int unsigned NUM_PIXELS = 16,
  parameter int unsigned IDX_W      = $clog2(NUM_PIXELS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_addr,
  input  logic [23:0]        wr_data,
  input  logic [IDX_W:0]     frame_len,
  input  logic               start,
  input  logic [7:0]         brightness,
  output logic               busy,
  output logic               done,
  output logic [23:0]        drv_data,
  output logic               drv_valid,
  output logic               drv_latch,
  input  logic               drv_ready
);

  localparam int unsigned LEN_W = IDX_W + 1;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(NUM_PIXELS);

  logic [PIXEL_W-1:0] r_pix_buf [NUM_PIXELS];

  state_t             r_state, w_state_d;
  logic [LEN_W-1:0]   r_len, w_len_d;
  logic [IDX_W-1:0]   r_idx, w_idx_d;
  logic [PIXEL_W-1:0] r_data, w_data_d;
  logic               r_valid, w_valid_d;
  logic               r_latch, w_latch_d;
  logic               r_busy, w_busy_d;
  logic               r_done, w_done_d;

  logic               w_last;
  logic [PIXEL_W-1:0] w_pix_raw;
  logic [PIXEL_W-1:0] w_pix;

  // Host write port, accepted in every state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PIXELS; i++) r_pix_buf[i] <= '0;
    end else if (wr_en && ({1'b0, wr_addr} < MAX_LEN)) begin
      r_pix_buf[wr_addr] <= wr_data;
    end
  end

  assign w_pix_raw = r_pix_buf[r_idx];
  assign w_last    = ({1'b0, r_idx} == (r_len - LEN_W'(1)));

`ifdef LEDSTRIP_BRIGHTNESS_EN
  ledstrip_pixel_scale u_scale_g (
    .i_ch(w_pix_raw[G_LSB +: CH_W]), .i_brightness(brightness), .o_ch(w_pix[G_LSB +: CH_W])
  );
  ledstrip_pixel_scale u_scale_r (
    .i_ch(w_pix_raw[R_LSB +: CH_W]), .i_brightness(brightness), .o_ch(w_pix[R_LSB +: CH_W])
  );
  ledstrip_pixel_scale u_scale_b (
    .i_ch(w_pix_raw[B_LSB +: CH_W]), .i_brightness(brightness), .o_ch(w_pix[B_LSB +: CH_W])
  );
`else
  logic w_unused_brightness;
  assign w_unused_brightness = ^brightness;
  assign w_pix = w_pix_raw;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_len   <= '0;
      r_idx   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_latch <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_len   <= w_len_d;
      r_idx   <= w_idx_d;
      r_data  <= w_data_d;
      r_valid <= w_valid_d;
      r_latch <= w_latch_d;
      r_busy  <= w_busy_d;
      r_done  <= w_done_d;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    w_state_d = r_state;
    w_len_d   = r_len;
    w_idx_d   = r_idx;
    w_data_d  = r_data;
    w_valid_d = r_valid;
    w_latch_d = r_latch;
    w_busy_d  = r_busy;
    w_done_d  = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        // A start coinciding with the done pulse is dropped
        if (start && !r_done) begin
          w_idx_d = '0;
          if (frame_len == '0) begin
            w_len_d  = '0;
            w_done_d = 1'b1;
          end else begin
            w_len_d   = (frame_len > MAX_LEN) ? MAX_LEN : frame_len;
            w_busy_d  = 1'b1;
            w_state_d = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        w_data_d  = w_pix;
        w_latch_d = w_last;
        w_valid_d = 1'b1;
        w_state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (r_valid && drv_ready) begin
          w_valid_d = 1'b0;
          w_latch_d = 1'b0;
          if (w_last) begin
            w_state_d = S_DRAIN;
          end else begin
            w_idx_d   = r_idx + IDX_W'(1);
            w_state_d = S_FETCH;
          end
        end
      end
      S_DRAIN: begin
        // Ready returning high marks the end of the strip reset gap
        if (drv_ready) begin
          w_done_d  = 1'b1;
          w_busy_d  = 1'b0;
          w_state_d = S_IDLE;
        end
      end
      default: w_state_d = S_IDLE;
    endcase
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign drv_data  = r_data;
  assign drv_valid = r_valid;
  assign drv_latch = r_latch;

endmodule

// File: tb/tb_ledstrip_frame_seq.sv
// Directed self-checking bench for ledstrip_frame_seq with a behavioural driver ready model.
module tb_ledstrip_frame_seq;
  import ledstrip_pkg::*;

  localparam int unsigned NUM_PIXELS = 16;
  localparam int unsigned IDX_W      = 4;
  localparam int unsigned GAP        = 6;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             wr_en;
  logic [IDX_W-1:0] wr_addr;
  logic [23:0]      wr_data;
  logic [IDX_W:0]   frame_len;
  logic             start;
  logic [7:0]       brightness;
  logic             busy, done, drv_valid, drv_latch, drv_ready;
  logic [23:0]      drv_data;

  int tests = 0;
  int fails = 0;

  ledstrip_frame_seq #(.NUM_PIXELS(NUM_PIXELS), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_len(frame_len), .start(start), .brightness(brightness),
    .busy(busy), .done(done), .drv_data(drv_data), .drv_valid(drv_valid),
    .drv_latch(drv_latch), .drv_ready(drv_ready)
  );

  always #5 clk = ~clk;

  // Driver model: ready drops after acceptance, returns after GAP+1 cycles
  logic rdy, hold;
  int   rcnt;
  assign drv_ready = rdy && !hold;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy  <= 1'b1;
      rcnt <= 0;
    end else if (drv_valid && drv_ready) begin
      rdy  <= 1'b0;
      rcnt <= GAP;
    end else if (!rdy) begin
      if (rcnt == 0) rdy <= 1'b1;
      else rcnt <= rcnt - 1;
    end
  end

  // Handshake / done / protocol monitor
  logic [23:0] hs_data  [128];
  logic        hs_latch [128];
  int          hs_cyc   [128];
  int          hs_total = 0;
  int          done_total = 0;
  int          done_cyc = 0;
  int          bad_total = 0;
  int          cyc = 0;

  always @(posedge clk) begin
    if (rst_n) begin
      if (drv_valid && drv_ready && hs_total < 128) begin
        hs_data[hs_total]  <= drv_data;
        hs_latch[hs_total] <= drv_latch;
        hs_cyc[hs_total]   <= cyc;
        hs_total           <= hs_total + 1;
      end
      if (done) begin
        done_cyc   <= cyc;
        done_total <= done_total + 1;
      end
      if ((drv_valid && !busy) || (drv_latch && !drv_valid)) bad_total <= bad_total + 1;
    end
    cyc <= cyc + 1;
  end

  task automatic write_px(input int addr, input logic [23:0] data);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = IDX_W'(addr); wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_start(input int len);
    @(negedge clk);
    frame_len = (IDX_W+1)'(len); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL %s: done timeout, got done=%0b want 1", name, done);
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %0b want 0", done); end
    tests++; if (drv_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b want 0", drv_valid); end
    tests++; if (drv_data !== 24'h0) begin fails++; $display("FAIL reset_data: got %h want 0", drv_data); end
    tests++; if (drv_latch !== 1'b0) begin fails++; $display("FAIL reset_latch: got %0b want 0", drv_latch); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int base = hs_total;
    int dbase = done_total;
    int viol = 0;
    int n = 0;
    logic [23:0] exp_d [3];
    exp_d[0] = 24'hFF0000; exp_d[1] = 24'h00FF00; exp_d[2] = 24'h0000FF;
    for (int i = 0; i < 3; i++) write_px(i, exp_d[i]);
    pulse_start(3);
    while (!done && n < 3000) begin
      if (!busy) viol++;
      @(negedge clk);
      n++;
    end
    tests++; if (!done) begin fails++; $display("FAIL basic_done: timeout got done=0 want 1"); end
    tests++; if (viol != 0) begin fails++; $display("FAIL basic_busy: %0d cycles busy=0, want 0", viol); end
    @(negedge clk);
    tests++; if (hs_total - base != 3) begin fails++; $display("FAIL basic_count: got %0d want 3", hs_total - base); end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (hs_data[base+i] !== exp_d[i] || hs_latch[base+i] !== (i == 2)) begin
        fails++;
        $display("FAIL basic_px%0d: got %h/latch %0b want %h/latch %0b",
                 i, hs_data[base+i], hs_latch[base+i], exp_d[i], (i == 2));
      end
    end
    tests++; if (done_total - dbase != 1) begin fails++; $display("FAIL basic_done_count: got %0d want 1", done_total - dbase); end
    tests++;
    if (done_cyc - hs_cyc[base+2] != int'(GAP) + 3) begin
      fails++;
      $display("FAIL basic_done_gap: got %0d want %0d", done_cyc - hs_cyc[base+2], GAP + 3);
    end
  endtask

  task automatic test_zero_len;
    int base = hs_total;
    int bz = 0;
    pulse_start(0);
    tests++; if (done !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL zero_done: got done=%0b busy=%0b want 1/0", done, busy); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy || drv_valid || done) bz++;
    end
    tests++; if (bz != 0) begin fails++; $display("FAIL zero_quiet: got %0d active cycles want 0", bz); end
    tests++; if (hs_total != base) begin fails++; $display("FAIL zero_traffic: got %0d handshakes want 0", hs_total - base); end
  endtask

  task automatic test_stall;
    int base = hs_total;
    int n = 0;
    int unstable = 0;
    logic [23:0] d0;
    logic l0;
    write_px(0, 24'hA1B2C3);
    write_px(1, 24'h0F0E0D);
    hold = 1'b1;
    pulse_start(2);
    while (!drv_valid && n < 100) begin @(negedge clk); n++; end
    d0 = drv_data; l0 = drv_latch;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (drv_valid !== 1'b1 || drv_data !== d0 || drv_latch !== l0) unstable++;
    end
    tests++; if (unstable != 0 || d0 !== 24'hA1B2C3 || l0 !== 1'b0) begin
      fails++; $display("FAIL stall_hold: %0d unstable, data %h latch %0b want A1B2C3/0", unstable, d0, l0);
    end
    hold = 1'b0;
    @(negedge clk);
    tests++; if (hs_total - base != 1 || drv_valid !== 1'b0) begin
      fails++; $display("FAIL stall_release: got %0d hs valid=%0b want 1/0", hs_total - base, drv_valid);
    end
    wait_done("stall");
    tests++; if (hs_data[base+1] !== 24'h0F0E0D || hs_latch[base+1] !== 1'b1) begin
      fails++; $display("FAIL stall_px1: got %h/%0b want 0F0E0D/1", hs_data[base+1], hs_latch[base+1]);
    end
  endtask

  task automatic test_midframe;
    int base, dbase;
    int n = 0;
    int lat_bad = 0;
    for (int i = 0; i < 8; i++) write_px(i, 24'h010101 * 24'(i + 1));
    base = hs_total; dbase = done_total;
    pulse_start(8);
    while (hs_total - base < 2 && n < 500) begin @(negedge clk); n++; end
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 24'h123456; start = 1'b1; frame_len = 5'd3;
    @(negedge clk);
    wr_en = 1'b0; start = 1'b0;
    wait_done("midframe");
    repeat (20) @(negedge clk);
    tests++; if (hs_total - base != 8) begin fails++; $display("FAIL mid_count: got %0d want 8", hs_total - base); end
    tests++; if (hs_data[base+5] !== 24'h123456) begin fails++; $display("FAIL mid_px5: got %h want 123456", hs_data[base+5]); end
    tests++; if (hs_data[base+2] !== 24'h030303) begin fails++; $display("FAIL mid_px2: got %h want 030303", hs_data[base+2]); end
    for (int i = 0; i < 8; i++) if (hs_latch[base+i] !== (i == 7)) lat_bad++;
    tests++; if (lat_bad != 0) begin fails++; $display("FAIL mid_latch: got %0d wrong latch flags want 0", lat_bad); end
    tests++; if (done_total - dbase != 1 || busy !== 1'b0) begin
      fails++; $display("FAIL mid_restart: got %0d done busy=%0b want 1/0", done_total - dbase, busy);
    end
  endtask

  task automatic test_clamp;
    int base = hs_total;
    pulse_start(20);
    wait_done("clamp");
    tests++; if (hs_total - base != 16 || hs_latch[base+15] !== 1'b1 || hs_latch[base+14] !== 1'b0) begin
      fails++; $display("FAIL clamp: got %0d hs latch15=%0b want 16/1", hs_total - base, hs_latch[base+15]);
    end
  endtask

  task automatic test_reset_midframe;
    int base;
    int n = 0;
    write_px(0, 24'hDEAD01);
    write_px(1, 24'hBEEF02);
    base = hs_total;
    hold = 1'b0;
    pulse_start(2);
    while (hs_total - base < 1 && n < 200) begin @(negedge clk); n++; end
    hold = 1'b1;
    n = 0;
    while (!drv_valid && n < 200) begin @(negedge clk); n++; end
    tests++; if (drv_data !== 24'hBEEF02) begin fails++; $display("FAIL rstmid_px1: got %h want BEEF02", drv_data); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (drv_valid !== 1'b0 || busy !== 1'b0 || drv_data !== 24'h0 || drv_latch !== 1'b0) begin
      fails++; $display("FAIL rstmid_async: got valid=%0b busy=%0b data=%h latch=%0b want 0", drv_valid, busy, drv_data, drv_latch);
    end
    @(negedge clk);
    rst_n = 1'b1; hold = 1'b0;
    base = hs_total;
    pulse_start(1);
    wait_done("rstmid");
    tests++; if (hs_total - base != 1 || hs_data[base] !== 24'h0 || hs_latch[base] !== 1'b1) begin
      fails++; $display("FAIL rstmid_frame: got %0d hs data %h latch %0b want 1/000000/1", hs_total - base, hs_data[base], hs_latch[base]);
    end
  endtask

`ifdef LEDSTRIP_BRIGHTNESS_EN
  task automatic test_brightness;
    int base;
    write_px(0, 24'h80FF40);
    brightness = 8'd127;
    base = hs_total;
    pulse_start(1);
    wait_done("bright127");
    tests++; if (hs_data[base] !== 24'h407F20) begin fails++; $display("FAIL bright127: got %h want 407F20", hs_data[base]); end
    brightness = 8'd255;
    base = hs_total;
    pulse_start(1);
    wait_done("bright255");
    tests++; if (hs_data[base] !== 24'h80FF40) begin fails++; $display("FAIL bright255: got %h want 80FF40", hs_data[base]); end
  endtask
`endif

  initial begin
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; frame_len = '0; start = 1'b0;
    brightness = 8'd255; hold = 1'b0; rst_n = 1'b1;
    #1;
    test_reset;
    test_basic;
    test_zero_len;
    test_stall;
    test_midframe;
    test_clamp;
    test_reset_midframe;
`ifdef LEDSTRIP_BRIGHTNESS_EN
    test_brightness;
`endif
    tests++; if (bad_total != 0) begin fails++; $display("FAIL protocol: got %0d violations want 0", bad_total); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
